// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: opcodes, ALU codes, FSM states,
// PC source selects and instruction classes.
package multicycle_control_pkg;

    localparam logic [3:0] OpLd  = 4'b0000;
    localparam logic [3:0] OpSt  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0011;
    localparam logic [3:0] OpInv = 4'b0100;
    localparam logic [3:0] OpLsl = 4'b0101;
    localparam logic [3:0] OpLsr = 4'b0110;
    localparam logic [3:0] OpAnd = 4'b0111;
    localparam logic [3:0] OpOr  = 4'b1000;
    localparam logic [3:0] OpSlt = 4'b1001;
    localparam logic [3:0] OpBeq = 4'b1011;
    localparam logic [3:0] OpBne = 4'b1100;
    localparam logic [3:0] OpJmp = 4'b1101;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluInv = 3'b010;
    localparam logic [2:0] AluLsl = 3'b011;
    localparam logic [2:0] AluLsr = 3'b100;
    localparam logic [2:0] AluAnd = 3'b101;
    localparam logic [2:0] AluOr  = 3'b110;
    localparam logic [2:0] AluSlt = 3'b111;

    localparam logic [1:0] PcPlus2  = 2'b00;
    localparam logic [1:0] PcBranch = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ClsRtype,
        ClsLoad,
        ClsStore,
        ClsBranch,
        ClsJump,
        ClsIllegal
    } opclass_e;

endpackage

// File: rtl/multicycle_control_opclass_decode.sv
// Maps the 4-bit opcode to its instruction class; unmapped opcodes are illegal.
module opclass_decode
    import multicycle_control_pkg::*;
(
    input  logic [3:0] opcode,
    output opclass_e   opclass
);

    always_comb begin
        opclass = ClsIllegal;
        case (opcode)
            OpLd:                          opclass = ClsLoad;
            OpSt:                          opclass = ClsStore;
            OpAdd, OpSub, OpInv, OpLsl,
            OpLsr, OpAnd, OpOr, OpSlt:     opclass = ClsRtype;
            OpBeq, OpBne:                  opclass = ClsBranch;
            OpJmp:                         opclass = ClsJump;
            default:                       opclass = ClsIllegal;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB) with stall freeze and a
// retired-instruction counter.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          opcode,
    input  logic                zero_flag,
    input  logic                mem_ready,
    input  logic                stall,
    output logic                ir_write,
    output logic                pc_write,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                alu_src_b,
    output logic                illegal,
    output logic [1:0]          pc_src,
    output logic [2:0]          alu_op,
    output logic [2:0]          state,
    output logic [RETIRE_W-1:0] retired
);

    state_e              state_q, state_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    opclass_e            opclass;
    logic                retire_inc;
    logic                taken;

    // Ungated strobes/selects, before stall and reset masking
    logic       ir_w, pc_w, reg_w, mem_r, mem_w, m2r, rdst, srcb, ill;
    logic [1:0] pc_s;
    logic [2:0] alu;

    opclass_decode u_opclass_decode (
        .opcode  (opcode),
        .opclass (opclass)
    );

    assign taken = (opcode == OpBeq) ? zero_flag : !zero_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        retire_inc = 1'b0;
        ir_w       = 1'b0;
        pc_w       = 1'b0;
        reg_w      = 1'b0;
        mem_r      = 1'b0;
        mem_w      = 1'b0;
        m2r        = 1'b0;
        rdst       = 1'b0;
        srcb       = 1'b0;
        ill        = 1'b0;
        pc_s       = PcPlus2;
        alu        = AluAdd;
        case (state_q)
            StFetch: begin
                mem_r = 1'b1;
                if (mem_ready) begin
                    ir_w    = 1'b1;
                    pc_w    = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: state_d = StExec;
            StExec: begin
                case (opclass)
                    ClsRtype: begin
                        alu     = opcode[2:0] - 3'd2;
                        state_d = StWb;
                    end
                    ClsLoad, ClsStore: begin
                        srcb    = 1'b1;
                        state_d = StMem;
                    end
                    ClsBranch: begin
                        alu        = AluSub;
                        pc_w       = taken;
                        pc_s       = taken ? PcBranch : PcPlus2;
                        retire_inc = 1'b1;
                        state_d    = StFetch;
                    end
                    ClsJump: begin
                        pc_w       = 1'b1;
                        pc_s       = PcJump;
                        retire_inc = 1'b1;
                        state_d    = StFetch;
                    end
                    default: begin
                        ill     = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StMem: begin
                if (opclass == ClsLoad) begin
                    mem_r = 1'b1;
                    if (mem_ready) state_d = StWb;
                end else if (opclass == ClsStore) begin
                    mem_w = 1'b1;
                    if (mem_ready) begin
                        retire_inc = 1'b1;
                        state_d    = StFetch;
                    end
                end else begin
                    state_d = StFetch;
                end
            end
            StWb: begin
                reg_w      = 1'b1;
                m2r        = (opclass == ClsLoad);
                rdst       = (opclass == ClsRtype);
                retire_inc = 1'b1;
                state_d    = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // A stalled cycle is a no-op: nothing advances and nothing is written
        if (stall) begin
            state_d    = state_q;
            retire_inc = 1'b0;
        end
    end

    assign retired_d = retired_q + RETIRE_W'(retire_inc);

    assign ir_write   = ir_w  & ~stall & ~rst;
    assign pc_write   = pc_w  & ~stall & ~rst;
    assign reg_write  = reg_w & ~stall & ~rst;
    assign mem_write  = mem_w & ~stall & ~rst;
    assign illegal    = ill   & ~stall & ~rst;
    assign mem_read   = mem_r & ~rst;
    assign mem_to_reg = m2r   & ~rst;
    assign reg_dst    = rdst  & ~rst;
    assign alu_src_b  = srcb  & ~rst;
    assign pc_src     = rst ? PcPlus2 : pc_s;
    assign alu_op     = rst ? AluAdd : alu;
    assign state      = state_q;
    assign retired    = retired_q;

endmodule
